// File: rtl/demux_lane_scheduler.sv
// Round-robin byte scheduler feeding four lanes, skipping disabled/almost-full lanes.
// Optional per-lane dispatch counters are enabled with `define LANE_CNT_EN.
module demux_lane_scheduler #(
    parameter int DATA_W = 8
`ifdef LANE_CNT_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              pause_out,
    input  logic [3:0]        lane_enable,
    input  logic [3:0]        lane_full,
    output logic [DATA_W-1:0] data_out0,
    output logic [DATA_W-1:0] data_out1,
    output logic [DATA_W-1:0] data_out2,
    output logic [DATA_W-1:0] data_out3,
    output logic              valid_out0,
    output logic              valid_out1,
    output logic              valid_out2,
    output logic              valid_out3,
`ifdef LANE_CNT_EN
    output logic [CNT_W-1:0]  lane_cnt0,
    output logic [CNT_W-1:0]  lane_cnt1,
    output logic [CNT_W-1:0]  lane_cnt2,
    output logic [CNT_W-1:0]  lane_cnt3,
`endif
    output logic [1:0]        cur_lane,
    output logic              error
);

    typedef enum logic [1:0] {IDLE, STALL, RUN} state_t;

    state_t            state, next_state;
    logic [3:0]        eligible;
    logic              accept;
    logic              found;
    logic [1:0]        sel;
    logic [1:0]        idx;
    logic              dispatch;
    logic [DATA_W-1:0] data_q [4];
    logic [3:0]        valid_q;

    assign eligible = lane_enable & ~lane_full;

    always_comb begin
        next_state = RUN;
        if (lane_enable == 4'b0000)
            next_state = IDLE;
        else if (eligible == 4'b0000)
            next_state = STALL;
    end

    always_ff @(posedge clk) begin
        if (!reset_L)
            state <= IDLE;
        else
            state <= next_state;
    end

    // The state register doubles as the registered pause flag: reset lands in IDLE.
    assign pause_out = (state != RUN);
    assign accept    = valid_in & ~pause_out;

    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int unsigned off = 0; off < 4; off++) begin
            idx = cur_lane + 2'(off);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    assign dispatch = accept & found;

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            for (int unsigned i = 0; i < 4; i++)
                data_q[i] <= '0;
            valid_q  <= '0;
            cur_lane <= '0;
            error    <= 1'b0;
        end else begin
            valid_q <= '0;
            if (dispatch) begin
                data_q[sel]  <= data_in;
                valid_q[sel] <= 1'b1;
                cur_lane     <= sel + 2'd1;
            end
            if (valid_in && (pause_out || !found))
                error <= 1'b1;
        end
    end

    assign data_out0  = data_q[0];
    assign data_out1  = data_q[1];
    assign data_out2  = data_q[2];
    assign data_out3  = data_q[3];
    assign valid_out0 = valid_q[0];
    assign valid_out1 = valid_q[1];
    assign valid_out2 = valid_q[2];
    assign valid_out3 = valid_q[3];

`ifdef LANE_CNT_EN
    logic [CNT_W-1:0] cnt_q [4];

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            for (int unsigned i = 0; i < 4; i++)
                cnt_q[i] <= '0;
        end else if (dispatch) begin
            cnt_q[sel] <= cnt_q[sel] + CNT_W'(1);
        end
    end

    assign lane_cnt0 = cnt_q[0];
    assign lane_cnt1 = cnt_q[1];
    assign lane_cnt2 = cnt_q[2];
    assign lane_cnt3 = cnt_q[3];
`endif

endmodule

// File: tb/tb_demux_lane_scheduler.sv
// Directed self-checking bench for demux_lane_scheduler (counter checks when LANE_CNT_EN is defined).
module tb_demux_lane_scheduler;

    logic       clk = 1'b0;
    logic       reset_L;
    logic [7:0] data_in;
    logic       valid_in;
    logic       pause_out;
    logic [3:0] lane_enable;
    logic [3:0] lane_full;
    logic [7:0] data_out0, data_out1, data_out2, data_out3;
    logic       valid_out0, valid_out1, valid_out2, valid_out3;
    logic [1:0] cur_lane;
    logic       error;
`ifdef LANE_CNT_EN
    logic [1:0] lane_cnt0, lane_cnt1, lane_cnt2, lane_cnt3;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

`ifdef LANE_CNT_EN
    demux_lane_scheduler #(.DATA_W(8), .CNT_W(2)) dut (
`else
    demux_lane_scheduler #(.DATA_W(8)) dut (
`endif
        .clk        (clk),
        .reset_L    (reset_L),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .pause_out  (pause_out),
        .lane_enable(lane_enable),
        .lane_full  (lane_full),
        .data_out0  (data_out0),
        .data_out1  (data_out1),
        .data_out2  (data_out2),
        .data_out3  (data_out3),
        .valid_out0 (valid_out0),
        .valid_out1 (valid_out1),
        .valid_out2 (valid_out2),
        .valid_out3 (valid_out3),
`ifdef LANE_CNT_EN
        .lane_cnt0  (lane_cnt0),
        .lane_cnt1  (lane_cnt1),
        .lane_cnt2  (lane_cnt2),
        .lane_cnt3  (lane_cnt3),
`endif
        .cur_lane   (cur_lane),
        .error      (error)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] vmask();
        return {valid_out3, valid_out2, valid_out1, valid_out0};
    endfunction

    function automatic logic [7:0] dout(input int k);
        case (k)
            0:       return data_out0;
            1:       return data_out1;
            2:       return data_out2;
            default: return data_out3;
        endcase
    endfunction

    // Present one byte for one cycle and check it lands on the expected lane.
    task automatic send(input string tag, input logic [7:0] d, input int lane);
        valid_in = 1'b1;
        data_in  = d;
        tick();
        chk({tag, "_valid"}, 32'(vmask()), 32'(4'b0001 << lane));
        chk({tag, "_data"}, 32'(dout(lane)), 32'(d));
        chk({tag, "_cur"}, 32'(cur_lane), 32'((lane + 1) % 4));
    endtask

    initial begin
        reset_L     = 1'b0;
        data_in     = '0;
        valid_in    = 1'b0;
        lane_enable = 4'h0;
        lane_full   = 4'h0;
        tick();
        tick();
        chk("rst_pause", 32'(pause_out), 32'd1);
        chk("rst_cur", 32'(cur_lane), 32'd0);
        chk("rst_err", 32'(error), 32'd0);
        chk("rst_valid", 32'(vmask()), 32'd0);
        chk("rst_data", {data_out3, data_out2, data_out1, data_out0}, 32'd0);

        // Full-rate round robin over all four lanes.
        reset_L     = 1'b1;
        lane_enable = 4'hF;
        tick();
        chk("t1_pause", 32'(pause_out), 32'd0);
        for (int i = 0; i < 8; i++)
            send("t1", 8'hA0 + 8'(i), i % 4);
        valid_in = 1'b0;
        chk("t1_d0", 32'(data_out0), 32'hA4);
        chk("t1_d3", 32'(data_out3), 32'hA7);
        chk("t1_err", 32'(error), 32'd0);
        tick();
        chk("t1_idle_valid", 32'(vmask()), 32'd0);
        chk("t1_hold_d3", 32'(data_out3), 32'hA7);

        // Lane 1 almost-full is skipped.
        lane_full = 4'b0010;
        send("t2a", 8'hB0, 0);
        send("t2b", 8'hB1, 2);
        send("t2c", 8'hB2, 3);
        send("t2d", 8'hB3, 0);
        valid_in = 1'b0;
        chk("t2_d1", 32'(data_out1), 32'hA5);

        // All full stalls the source; freeing lane 2 resumes it.
        lane_full = 4'hF;
        tick();
        chk("t3_stall", 32'(pause_out), 32'd1);
        lane_full = 4'b1011;
        tick();
        chk("t3_resume", 32'(pause_out), 32'd0);
        send("t3", 8'hC0, 2);
        valid_in = 1'b0;
        chk("t3_err", 32'(error), 32'd0);

        // Valid while paused in IDLE drops the byte and sets sticky error.
        lane_enable = 4'h0;
        lane_full   = 4'h0;
        tick();
        chk("t4_pause", 32'(pause_out), 32'd1);
        valid_in = 1'b1;
        data_in  = 8'h55;
        tick();
        chk("t4_valid", 32'(vmask()), 32'd0);
        chk("t4_err", 32'(error), 32'd1);
        valid_in    = 1'b0;
        lane_enable = 4'hF;
        tick();
        tick();
        chk("t4_sticky", 32'(error), 32'd1);
        chk("t4_cur", 32'(cur_lane), 32'd3);
        chk("t4_d2", 32'(data_out2), 32'hC0);

        // Accept with no eligible lane in the same cycle is also a drop.
        reset_L = 1'b0;
        tick();
        chk("t5_err_clr", 32'(error), 32'd0);
        reset_L = 1'b1;
        tick();
        chk("t5_run", 32'(pause_out), 32'd0);
        valid_in  = 1'b1;
        data_in   = 8'h66;
        lane_full = 4'hF;
        tick();
        chk("t5_drop_valid", 32'(vmask()), 32'd0);
        chk("t5_drop_err", 32'(error), 32'd1);
        chk("t5_drop_cur", 32'(cur_lane), 32'd0);
        valid_in = 1'b0;

        // Reset the cycle after an accept discards everything.
        reset_L = 1'b0;
        tick();
        reset_L   = 1'b1;
        lane_full = 4'h0;
        tick();
        send("t5_acc", 8'h77, 0);
        reset_L = 1'b0;
        data_in = 8'h78;
        tick();
        chk("t5_rst_valid", 32'(vmask()), 32'd0);
        chk("t5_rst_pause", 32'(pause_out), 32'd1);
        chk("t5_rst_d0", 32'(data_out0), 32'd0);
        chk("t5_rst_cur", 32'(cur_lane), 32'd0);
        valid_in = 1'b0;
        reset_L  = 1'b1;
        tick();

`ifdef LANE_CNT_EN
        for (int i = 0; i < 10; i++)
            send("t6", 8'hD0 + 8'(i), i % 4);
        valid_in = 1'b0;
        chk("t6_cnt0", 32'(lane_cnt0), 32'd3);
        chk("t6_cnt1", 32'(lane_cnt1), 32'd3);
        chk("t6_cnt2", 32'(lane_cnt2), 32'd2);
        chk("t6_cnt3", 32'(lane_cnt3), 32'd2);
        lane_enable = 4'b0100;
        send("t6_w1", 8'hE0, 2);
        chk("t6_cnt2_a", 32'(lane_cnt2), 32'd3);
        send("t6_w2", 8'hE1, 2);
        chk("t6_cnt2_wrap", 32'(lane_cnt2), 32'd0);
        valid_in = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
